// File: rtl/rr_arb_mux.sv
// Multi-channel valid/ready arbiter (round-robin or fixed priority) that loads
// the winning channel's data and index into a one-entry registered output stage.
module rr_arb_mux #(
   parameter int WIDTH           = 32,
   parameter int INPUT_BUS_COUNT = 4,
   parameter int INDEX_WIDTH     = (INPUT_BUS_COUNT > 32'sd1) ? $clog2(INPUT_BUS_COUNT) : 32'sd1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       priority_mode,
   input  logic [INPUT_BUS_COUNT-1:0] in_valid,
   input  logic [WIDTH-1:0]           input_busses [INPUT_BUS_COUNT],
   output logic [INPUT_BUS_COUNT-1:0] in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           selected_data,
   output logic [INDEX_WIDTH-1:0]     selected_index
);

   logic [INDEX_WIDTH-1:0]     rr_pointer_r;
   logic                       out_valid_r;
   logic [WIDTH-1:0]           data_r;
   logic [INDEX_WIDTH-1:0]     index_r;

   logic                       accept_s;
   logic                       found_s;
   logic                       hit_s;
   logic                       transfer_s;
   int                         start_s;
   int                         best_dist_s;
   logic [INDEX_WIDTH-1:0]     grant_idx_s;
   logic [INDEX_WIDTH-1:0]     next_ptr_s;
   logic [INPUT_BUS_COUNT-1:0] grant_s;
   logic [WIDTH-1:0]           win_data_s;

   // Distance of channel idx from the scan start, walking upward and wrapping.
   function automatic int ring_dist(input int idx, input int start);
      return (idx >= start) ? (idx - start) : (idx + INPUT_BUS_COUNT - start);
   endfunction

   // Arbitration: the requesting channel closest to the scan start wins.
   // Fixed priority is the same scan anchored at channel 0.
   always_comb begin
      start_s     = priority_mode ? 32'sd0 : int'(rr_pointer_r);
      best_dist_s = INPUT_BUS_COUNT;
      found_s     = 1'b0;
      hit_s       = 1'b0;
      grant_idx_s = '0;
      for (int i = 0; i < INPUT_BUS_COUNT; i++) begin
         hit_s       = in_valid[i] && (ring_dist(i, start_s) < best_dist_s);
         best_dist_s = hit_s ? ring_dist(i, start_s) : best_dist_s;
         grant_idx_s = hit_s ? INDEX_WIDTH'(i) : grant_idx_s;
         found_s     = found_s || hit_s;
      end
   end

   // One-hot grant vector and the matching data word (AND-OR mux).
   always_comb begin
      grant_s    = '0;
      win_data_s = '0;
      for (int i = 0; i < INPUT_BUS_COUNT; i++) begin
         grant_s[i] = found_s && (grant_idx_s == INDEX_WIDTH'(i));
         win_data_s = win_data_s | (input_busses[i] & {WIDTH{grant_s[i]}});
      end
   end

   // Handshake and next pointer value.
   always_comb begin
      accept_s   = !out_valid_r || out_ready;
      in_ready   = grant_s & {INPUT_BUS_COUNT{accept_s}};
      transfer_s = found_s && accept_s;
      if (grant_idx_s == INDEX_WIDTH'(INPUT_BUS_COUNT - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_s + INDEX_WIDTH'(1'b1);
      end
   end

   // Output stage and round-robin pointer; reset discards any held word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r  <= 1'b0;
         data_r       <= '0;
         index_r      <= '0;
         rr_pointer_r <= '0;
      end else begin
         if (transfer_s) begin
            out_valid_r <= 1'b1;
            data_r      <= win_data_s;
            index_r     <= grant_idx_s;
         end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
         end
         // Fixed-priority transfers leave the rotation where it was.
         if (transfer_s && !priority_mode) begin
            rr_pointer_r <= next_ptr_s;
         end
      end
   end

   assign out_valid      = out_valid_r;
   assign selected_data  = data_r;
   assign selected_index = index_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel instance driven from a vector table
// plus hand-written backpressure/reset sequences, and a 3-channel wrap check.
module tb_rr_arb_mux;

   logic        clk;
   logic        reset;
   logic        pm4, or4, pm3, or3;
   logic [3:0]  iv4;
   logic [2:0]  iv3;
   logic [31:0] data4 [4];
   logic [31:0] data3 [3];
   logic [3:0]  ir4;
   logic [2:0]  ir3;
   logic        ov4, ov3;
   logic [31:0] sd4, sd3;
   logic [1:0]  si4, si3;

   int total = 0;
   int bad   = 0;

   rr_arb_mux #(.WIDTH(32), .INPUT_BUS_COUNT(4)) d4 (
      .clk(clk), .reset(reset), .priority_mode(pm4), .in_valid(iv4),
      .input_busses(data4), .in_ready(ir4), .out_valid(ov4), .out_ready(or4),
      .selected_data(sd4), .selected_index(si4)
   );

   rr_arb_mux #(.WIDTH(32), .INPUT_BUS_COUNT(3)) d3 (
      .clk(clk), .reset(reset), .priority_mode(pm3), .in_valid(iv3),
      .input_busses(data3), .in_ready(ir3), .out_valid(ov3), .out_ready(or3),
      .selected_data(sd3), .selected_index(si3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pm;
      logic [3:0]  iv;
      logic        ordy;
      logic [3:0]  ir;
      logic        ov;
      logic [31:0] d;
      logic [1:0]  ix;
      logic [1:0]  p;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic pm, input logic [3:0] iv, input logic ordy,
                               input logic [3:0] ir, input logic ov, input logic [31:0] d,
                               input logic [1:0] ix, input logic [1:0] p);
      vec_t r;
      r.pm = pm; r.iv = iv; r.ordy = ordy; r.ir = ir;
      r.ov = ov; r.d = d; r.ix = ix; r.p = p;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic post4(input string nm, input logic ov, input logic [31:0] d,
                        input logic [1:0] ix, input logic [1:0] p);
      chk({nm, " out_valid"}, 64'(ov4), 64'(ov));
      chk({nm, " data"}, 64'(sd4), 64'(d));
      chk({nm, " index"}, 64'(si4), 64'(ix));
      chk({nm, " pointer"}, 64'(d4.rr_pointer_r), 64'(p));
   endtask

   initial begin
      int     exp_ix3 [6];
      logic [2:0] exp_ir3 [6];
      logic [2:0] iv3_seq [6];
      int     exp_p3  [6];

      // ptr: after reset 0; RR 1111 x8 -> 0; 0011 x2 -> 2; fixed keeps 2; etc.
      vecs[0]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,  2'd0, 2'd0);
      vecs[1]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,  2'd0, 2'd0);
      vecs[2]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,  2'd0, 2'd0);
      vecs[3]  = mk(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0, 2'd1);
      vecs[4]  = mk(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);
      vecs[5]  = mk(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'hA2, 2'd2, 2'd3);
      vecs[6]  = mk(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3, 2'd0);
      vecs[7]  = mk(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0, 2'd1);
      vecs[8]  = mk(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);
      vecs[9]  = mk(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'hA2, 2'd2, 2'd3);
      vecs[10] = mk(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3, 2'd0);
      vecs[11] = mk(1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0, 2'd1);
      vecs[12] = mk(1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);
      vecs[13] = mk(1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);
      vecs[14] = mk(1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);
      vecs[15] = mk(1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);
      vecs[16] = mk(1'b1, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);
      vecs[17] = mk(1'b1, 4'b1001, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0, 2'd2);
      vecs[18] = mk(1'b0, 4'b0110, 1'b1, 4'b0100, 1'b1, 32'hA2, 2'd2, 2'd3);
      vecs[19] = mk(1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);
      vecs[20] = mk(1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3, 2'd0);
      vecs[21] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'hA3, 2'd3, 2'd0);
      vecs[22] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'hA3, 2'd3, 2'd0);
      vecs[23] = mk(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'hA0, 2'd0, 2'd1);
      vecs[24] = mk(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'hA0, 2'd0, 2'd1);
      vecs[25] = mk(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1, 2'd2);

      reset = 1'b1;
      pm4 = 1'b0; or4 = 1'b1; iv4 = 4'b0000;
      pm3 = 1'b0; or3 = 1'b1; iv3 = 3'b000;
      for (int i = 0; i < 4; i++) data4[i] = 32'hA0 + 32'(i);
      for (int i = 0; i < 3; i++) data3[i] = 32'hB0 + 32'(i);
      repeat (2) @(posedge clk);
      #1;
      post4("reset", 1'b0, 32'h0, 2'd0, 2'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int v = 0; v < NV; v++) begin
         @(negedge clk);
         pm4 = vecs[v].pm; iv4 = vecs[v].iv; or4 = vecs[v].ordy;
         #2;
         chk($sformatf("v%0d in_ready", v), 64'(ir4), 64'(vecs[v].ir));
         @(posedge clk);
         #1;
         post4($sformatf("v%0d", v), vecs[v].ov, vecs[v].d, vecs[v].ix, vecs[v].p);
      end

      // Backpressure: park 0xDEADBEEF from channel 3, then stall five cycles.
      @(negedge clk);
      data4[3] = 32'hDEADBEEF; pm4 = 1'b1; iv4 = 4'b1000; or4 = 1'b1;
      #2 chk("bp load in_ready", 64'(ir4), 64'(4'b1000));
      @(posedge clk); #1;
      post4("bp load", 1'b1, 32'hDEADBEEF, 2'd3, 2'd2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         pm4 = 1'b0; iv4 = 4'b1111; or4 = 1'b0;
         #2 chk($sformatf("bp stall%0d in_ready", c), 64'(ir4), 64'(4'b0000));
         @(posedge clk); #1;
         post4($sformatf("bp stall%0d", c), 1'b1, 32'hDEADBEEF, 2'd3, 2'd2);
      end
      @(negedge clk);
      or4 = 1'b1;
      #2 chk("bp release in_ready", 64'(ir4), 64'(4'b0100));
      @(posedge clk); #1;
      post4("bp release", 1'b1, 32'hA2, 2'd2, 2'd3);

      // Reset while a word is held under stall.
      @(negedge clk);
      data4[0] = 32'h1234; pm4 = 1'b1; iv4 = 4'b0001; or4 = 1'b1;
      @(posedge clk); #1;
      post4("rst load", 1'b1, 32'h1234, 2'd0, 2'd3);
      @(negedge clk);
      pm4 = 1'b0; iv4 = 4'b1111; or4 = 1'b0;
      @(posedge clk); #1;
      post4("rst hold", 1'b1, 32'h1234, 2'd0, 2'd3);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      post4("rst apply", 1'b0, 32'h0, 2'd0, 2'd0);
      @(negedge clk);
      reset = 1'b0; or4 = 1'b1;
      #2 chk("rst first in_ready", 64'(ir4), 64'(4'b0001));
      @(posedge clk); #1;
      post4("rst first", 1'b1, 32'h1234, 2'd0, 2'd1);

      // Three-channel instance: wrap past the last channel.
      @(negedge clk);
      iv4 = 4'b0000;
      iv3_seq = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b110, 3'b011};
      exp_ir3 = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b010, 3'b001};
      exp_ix3 = '{0, 2, 0, 2, 1, 0};
      exp_p3  = '{1, 0, 1, 0, 2, 1};
      for (int s = 0; s < 6; s++) begin
         if (s > 0) @(negedge clk);
         iv3 = iv3_seq[s];
         #2 chk($sformatf("n3 s%0d in_ready", s), 64'(ir3), 64'(exp_ir3[s]));
         @(posedge clk); #1;
         chk($sformatf("n3 s%0d out_valid", s), 64'(ov3), 64'(1'b1));
         chk($sformatf("n3 s%0d index", s), 64'(si3), 64'(exp_ix3[s]));
         chk($sformatf("n3 s%0d data", s), 64'(sd3), 64'(32'hB0 + 32'(exp_ix3[s])));
         chk($sformatf("n3 s%0d pointer", s), 64'(d3.rr_pointer_r), 64'(exp_p3[s]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the combinational bus mux.
- Selects one of INPUT_BUS_COUNT valid/ready input channels, using round-robin or fixed-priority arbitration.
- Registers the winning data and its channel index into a one-entry output stage with a valid/ready handshake.
- Used wherever several pipeline sources share one consumer, e.g. writeback or memory request merging.

Parameters:
- WIDTH, 32: data width of each input bus and of the output.
- INPUT_BUS_COUNT, 4: number of input channels. Legal range is 1 or more; non-power-of-two values are legal.
- INDEX_WIDTH, max(1, $clog2(INPUT_BUS_COUNT)): width of the index/pointer. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- priority_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- in_valid  input  INPUT_BUS_COUNT  per-channel request.
- input_busses  input  WIDTH x INPUT_BUS_COUNT (unpacked array)  per-channel data.
- in_ready  output  INPUT_BUS_COUNT  per-channel accept (combinational).
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts output this cycle.
- selected_data  output  WIDTH  registered winning data.
- selected_index  output  INDEX_WIDTH  registered index of winning channel.

Behaviour:
- Reset (sync, active-high, sampled on clk edge):
  - out_valid=0, selected_data=0, selected_index=0, rr_pointer=0.
  - Reset overrides any simultaneous transfer; held output data is discarded.
- accept = !out_valid || out_ready. The output register may load this cycle only if accept=1.
- Grant (combinational, one-hot or zero):
  - Round-robin: first i with in_valid[i]=1, scanning rr_pointer, rr_pointer+1, ..., wrapping at INPUT_BUS_COUNT-1 to 0.
  - Fixed priority: lowest i with in_valid[i]=1.
  - No in_valid asserted: grant all zero.
- in_ready[i] = grant[i] && accept. At most one in_ready bit is high. in_ready never depends on in_valid[j] for j != i other than through arbitration.
- Transfer on channel i when in_valid[i] && in_ready[i]. Next edge:
  - selected_data = input_busses[i]
  - selected_index = i
  - out_valid = 1
- Latency: data appears at the output 1 cycle after acceptance. Full throughput: one transfer per cycle when out_ready is held high.
- Output consumed (out_valid && out_ready) with no new transfer: out_valid=0 next edge. selected_data and selected_index hold their last values.
- Stall (out_valid && !out_ready): selected_data, selected_index and out_valid hold stable. All in_ready=0.
- Pointer update: only on a transfer while priority_mode=0. rr_pointer = (granted index == INPUT_BUS_COUNT-1) ? 0 : granted index + 1. Held otherwise, including in fixed mode.
- priority_mode may change on any cycle. It takes effect for the grant in that same cycle; no state is flushed.
- INPUT_BUS_COUNT=1: grant = in_valid[0] && accept. selected_index is always 0. Pointer stays 0.
- Inputs must hold data stable while in_valid && !in_ready (source obligation). The block does not check this.

Test Plan:
- Reset, then: all in_valid=0, out_ready=1 for 3 cycles -> out_valid=0, selected_data=0, selected_index=0, in_ready=0000.
- RR fairness: N=4, all in_valid=1111, data[i]=0xA0+i, out_ready=1 for 8 cycles -> selected_index sequence 0,1,2,3,0,1,2,3, selected_data 0xA0..0xA3 repeating, each 1 cycle after its in_ready pulse.
- Fixed priority: priority_mode=1, in_valid=0110 for 4 cycles -> selected_index=1 every cycle; in_ready[2]=0 throughout. Switch to priority_mode=0 -> next grant is channel 2 (pointer=2 from reset state 0 + earlier RR history).
- Backpressure: load channel 3 with 0xDEADBEEF, then out_ready=0 for 5 cycles with in_valid=1111 -> output holds 0xDEADBEEF/index 3, in_ready=0000. Raise out_ready -> same-cycle accept, new data next edge.
- Wrap and non-power-of-two: N=3, in_valid=101, out_ready=1 -> indices alternate 0,2,0,2. pointer goes 1,0,1,0. selected_index never 3.
- Reset mid-stall: out_valid=1 holding 0x1234, assert reset one cycle with out_ready=0 -> next edge out_valid=0, selected_data=0, pointer=0. The first post-reset grant with in_valid=1111 is channel 0.
